// File: rtl/booth_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_arbiter
// Function : Round-robin sharing of one 5-bit serial-bus Booth multiplier
//            among N clients. Optional WAIT watchdog: BOOTH_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module booth_mul_arbiter #(
  parameter int N       = 3,
  parameter int TIMEOUT = 20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [5*N-1:0] a_in,
  input  logic [5*N-1:0] b_in,
  output logic [N-1:0]   ack,
  output logic           err,
  output logic [9:0]     product,
  output logic           mul_rst,
  output logic           mul_start,
  output logic [4:0]     mul_in,
  input  logic [4:0]     mul_out,
  input  logic           mul_done
);

  localparam int PW = (N > 2) ? 2 : 1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_MRST  = 4'd1;
  localparam logic [3:0] S_START = 4'd2;
  localparam logic [3:0] S_GAP   = 4'd3;
  localparam logic [3:0] S_LDA   = 4'd4;
  localparam logic [3:0] S_LDB   = 4'd5;
  localparam logic [3:0] S_WAIT  = 4'd6;
  localparam logic [3:0] S_RDH   = 4'd7;
  localparam logic [3:0] S_ACK   = 4'd8;

  logic [3:0]    r_state;
  logic [3:0]    w_next;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_grant;
  logic [PW-1:0] w_grant;
  logic [PW:0]   w_cand;
  logic          w_any;
  logic [4:0]    r_a;
  logic [4:0]    r_b;
  logic [9:0]    r_product;
  logic          w_timeout;
  logic          w_abort_ack;

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wait_cnt;
  logic          r_abort;

  assign w_timeout   = (r_state == S_WAIT) && !mul_done &&
                       (r_wait_cnt == CW'(TIMEOUT - 1));
  assign w_abort_ack = (r_state == S_ACK) && r_abort;
  assign err         = w_abort_ack && req[r_grant];

  // r_abort is only ever high during the ACK cycle that follows a timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 1'b1 : '0;
      r_abort    <= w_timeout;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign w_abort_ack = 1'b0;
  assign err         = 1'b0;
`endif

  if (N < 2 || N > 4 || TIMEOUT < 1) begin : g_bad_params
  end

  // Search downward so the last hit is the one closest to the pointer.
  always_comb begin
    w_grant = r_ptr;
    w_cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_cand = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_cand >= (PW+1)'(N)) begin
        w_cand = w_cand - (PW+1)'(N);
      end
      if (req[w_cand[PW-1:0]]) begin
        w_grant = w_cand[PW-1:0];
      end
    end
  end

  assign w_any = |req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_MRST;
      S_MRST:  w_next = S_START;
      S_START: w_next = S_GAP;
      S_GAP:   w_next = S_LDA;
      S_LDA:   w_next = S_LDB;
      S_LDB:   w_next = S_WAIT;
      S_WAIT: begin
        if (mul_done) begin
          w_next = S_RDH;
        end else if (w_timeout) begin
          w_next = S_ACK;
        end
      end
      S_RDH:   w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ack       = '0;
    mul_rst   = w_abort_ack;
    mul_start = 1'b0;
    mul_in    = '0;
    case (r_state)
      S_MRST:  mul_rst   = 1'b1;
      S_START: mul_start = 1'b1;
      S_LDA:   mul_in    = r_a;
      S_LDB:   mul_in    = r_b;
      S_ACK:   ack[r_grant] = req[r_grant];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_grant   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_product <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_grant <= w_grant;
        r_a     <= a_in[5*int'(w_grant) +: 5];
        r_b     <= b_in[5*int'(w_grant) +: 5];
      end
      if (r_state == S_WAIT && mul_done) begin
        r_product[4:0] <= mul_out;
      end else if (w_timeout) begin
        r_product <= '0;
      end
      if (r_state == S_RDH) begin
        r_product[9:5] <= mul_out;
      end
      // Pointer advances whether or not the client was still there to take the result.
      if (r_state == S_ACK) begin
        r_ptr <= (r_grant == PW'(N - 1)) ? '0 : r_grant + 1'b1;
      end
    end
  end

  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_arbiter.sv
`default_nettype none
// Bench for booth_mul_arbiter: behavioural serial multiplier and a result scoreboard.
module tb_booth_mul_arbiter;

  localparam int N       = 3;
  localparam int TIMEOUT = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [5*N-1:0] a_in;
  logic [5*N-1:0] b_in;
  logic [N-1:0]   ack;
  logic           err;
  logic [9:0]     product;
  logic           mul_rst;
  logic           mul_start;
  logic [4:0]     mul_in;
  logic [4:0]     mul_out  = 5'd0;
  logic           mul_done = 1'b0;

  booth_mul_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .ack       (ack),
    .err       (err),
    .product   (product),
    .mul_rst   (mul_rst),
    .mul_start (mul_start),
    .mul_in    (mul_in),
    .mul_out   (mul_out),
    .mul_done  (mul_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         client;
    logic [9:0] prod;
    logic       err;
    logic       mrst;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         ack_cnt = 0;
  int         last_ack_cyc = 0;
  int         t0 = 0;
  int         served[N];
  int         target[N];
  logic [N-1:0] req_drv;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] prod_of(logic [4:0] a, logic [4:0] b);
    logic signed [9:0] xa;
    logic signed [9:0] xb;
    xa = {{5{a[4]}}, a};
    xb = {{5{b[4]}}, b};
    return xa * xb;
  endfunction

  // A client keeps requesting until it has been served as often as asked.
  always_comb begin
    req = '0;
    for (int c = 0; c < N; c++) begin
      req[c] = req_drv[c] && (served[c] < target[c]);
    end
  end

  // Behavioural multiplier: start, gap, A, B, then done+low half, high half.
  int         m_phase = 0;
  int         m_cnt   = 0;
  int         m_dly   = 0;
  bit         m_never = 1'b0;
  logic [4:0] m_a;
  logic [9:0] m_p;
  logic [9:0] m_t;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mul_rst) begin
      m_phase  <= 0;
      mul_done <= 1'b0;
      mul_out  <= '0;
    end else begin
      case (m_phase)
        0: if (mul_start) m_phase <= 1;
        1: m_phase <= 2;
        2: begin m_a <= mul_in; m_phase <= 3; end
        3: begin
          m_t = prod_of(m_a, mul_in);
          m_p <= m_t;
          if (m_never) begin
            m_phase <= 7;
          end else if (m_dly == 0) begin
            mul_done <= 1'b1;
            mul_out  <= m_t[4:0];
            m_phase  <= 5;
          end else begin
            m_cnt   <= m_dly - 1;
            m_phase <= 4;
          end
        end
        4: begin
          if (m_cnt == 0) begin
            mul_done <= 1'b1;
            mul_out  <= m_p[4:0];
            m_phase  <= 5;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
        5: begin mul_done <= 1'b0; mul_out <= m_p[9:5]; m_phase <= 6; end
        6: begin mul_out <= '0; m_phase <= 0; end
        default: ;
      endcase
    end
  end

  // Result monitor: every ack is matched against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ack != '0) begin
      ack_cnt++;
      last_ack_cyc = cyc;
      check_eq("ack_onehot", $countones(ack), 1);
      for (int c = 0; c < N; c++) begin
        if (ack[c]) served[c]++;
      end
      if (sb.size() == 0) begin
        check_eq("unexpected_ack", 32'(ack), 0);
      end else begin
        e = sb.pop_front();
        check_eq("ack_client", 32'(ack), 32'(1) << e.client);
        check_eq("ack_product", 32'(product), 32'(e.prod));
        check_eq("ack_err", 32'(err), 32'(e.err));
        check_eq("ack_mul_rst", 32'(mul_rst), 32'(e.mrst));
      end
    end
  end

  task automatic set_client(int c, logic [4:0] a, logic [4:0] b, int times);
    a_in[5*c +: 5] = a;
    b_in[5*c +: 5] = b;
    target[c] = served[c] + times;
  endtask

  task automatic push_exp(int c);
    exp_t e;
    e.client = c;
    e.prod   = prod_of(a_in[5*c +: 5], b_in[5*c +: 5]);
    e.err    = 1'b0;
    e.mrst   = 1'b0;
    sb.push_back(e);
  endtask

  task automatic wait_drain(int max_cyc);
    int k = 0;
    while (sb.size() != 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a_before;
    rst     = 1'b1;
    req_drv = '0;
    a_in    = '0;
    b_in    = '0;
    for (int c = 0; c < N; c++) begin
      served[c] = 0;
      target[c] = 0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_ack", 32'(ack), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_product", 32'(product), 0);
    check_eq("rst_mul_ctl", {mul_rst, mul_start, mul_in}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single client 0, 3*5, done 10 cycles into WAIT
    m_dly = 10;
    set_client(0, 5'd3, 5'd5, 1);
    push_exp(0);
    req_drv = 3'b001;
    t0 = cyc;
    @(negedge clk); check_eq("seq_mrst", {mul_rst, mul_start}, 2'b10);
    @(negedge clk); check_eq("seq_start", {mul_rst, mul_start}, 2'b01);
    @(negedge clk); check_eq("seq_gap", {mul_rst, mul_start, mul_in}, 0);
    @(negedge clk); check_eq("seq_lda", 32'(mul_in), 3);
    @(negedge clk); check_eq("seq_ldb", 32'(mul_in), 5);
    wait_drain(40);
    check_eq("latency_18", last_ack_cyc - t0, 18);
    req_drv = '0;

    // Signed operands, immediate done: minimum latency
    m_dly = 0;
    set_client(2, 5'b11001, 5'd6, 1);
    push_exp(2);
    req_drv = 3'b100;
    t0 = cyc;
    wait_drain(40);
    check_eq("latency_min", last_ack_cyc - t0, 8);
    check_eq("signed_hold", 32'(product), 32'(10'b1111010110));
    req_drv = '0;

    // All three request together, pointer at 0: order 0,1,2,0
    m_dly = 2;
    set_client(0, 5'd5, 5'b11101, 2);
    set_client(1, 5'b10000, 5'b10000, 1);
    set_client(2, 5'd15, 5'd15, 1);
    push_exp(0); push_exp(1); push_exp(2); push_exp(0);
    req_drv = 3'b111;
    wait_drain(200);
    req_drv = '0;

    // Client 1 abandons its request during WAIT
    m_dly = 10;
    set_client(1, 5'd7, 5'd9, 1);
    req_drv = 3'b010;
    t0 = cyc;
    repeat (7) @(negedge clk);
    req_drv = 3'b000;
    repeat (11) @(negedge clk);
    check_eq("drop_no_ack", 32'(ack), 0);
    @(negedge clk);
    // Pointer must now be at 2, so client 0 wins over a returning client 1.
    set_client(0, 5'd9, 5'd3, 1);
    set_client(1, 5'b11111, 5'b10000, 1);
    push_exp(0); push_exp(1);
    req_drv = 3'b011;
    wait_drain(100);
    req_drv = '0;

    // Reset while operand A is on the bus
    m_dly = 3;
    set_client(2, 5'd11, 5'd13, 1);
    req_drv = 3'b100;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_lda", 32'(mul_in), 11);
    rst = 1'b1;
    #1;
    check_eq("midrst_ack", 32'(ack), 0);
    check_eq("midrst_product", 32'(product), 0);
    check_eq("midrst_mul_ctl", {mul_rst, mul_start, mul_in}, 0);
    @(negedge clk);
    rst = 1'b0;
    push_exp(2);
    t0 = cyc;
    @(negedge clk);
    check_eq("restart_mrst", 32'(mul_rst), 1);
    wait_drain(60);
    check_eq("restart_latency", last_ack_cyc - t0, 11);
    req_drv = '0;

    // Multiplier never completes
    m_never = 1'b1;
    set_client(0, 5'd4, 5'd4, 1);
`ifdef BOOTH_ARB_TIMEOUT_EN
    begin
      exp_t e;
      e.client = 0;
      e.prod   = 10'd0;
      e.err    = 1'b1;
      e.mrst   = 1'b1;
      sb.push_back(e);
    end
    req_drv = 3'b001;
    wait_drain(80);
    check_eq("timeout_product_hold", 32'(product), 0);
    req_drv = '0;
`else
    a_before = ack_cnt;
    req_drv = 3'b001;
    repeat (60) @(negedge clk);
    check_eq("no_watchdog_no_ack", ack_cnt, a_before);
    check_eq("no_watchdog_bus_idle", {mul_rst, mul_start, mul_in}, 0);
    req_drv = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    m_never = 1'b0;
    @(negedge clk);
    check_eq("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
